// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM state encoding and nibble width.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_e;

    // Index width for a nibble counter; never narrower than one bit.
    function automatic int nib_idx_w(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/CLA_4_bits.sv
// 4-bit carry-lookahead adder slice: fully parallel carries from generate/propagate terms.
module CLA_4_bits
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[NIBBLE_W-1:0];
    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder processing one nibble per cycle through a single CLA slice, valid/ready on both sides.
// Optional signed-overflow output ovf is enabled by defining NSA_OVERFLOW_FLAG_EN.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NSA_OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB_CNT = WIDTH / NIBBLE_W;
    localparam int IDX_W   = nib_idx_w(NIB_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB_CNT - 1);

    nsa_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef NSA_OVERFLOW_FLAG_EN
    logic               ovf_q, ovf_d;
`endif

    logic [NIBBLE_W-1:0] a_nib [NIB_CNT];
    logic [NIBBLE_W-1:0] b_nib [NIB_CNT];
    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
    logic                slice_cout;

    for (genvar gi = 0; gi < NIB_CNT; gi++) begin : g_nib
        assign a_nib[gi] = a_q[gi*NIBBLE_W +: NIBBLE_W];
        assign b_nib[gi] = b_q[gi*NIBBLE_W +: NIBBLE_W];
    end

    assign slice_a = a_nib[idx_q];
    assign slice_b = b_nib[idx_q];

    CLA_4_bits u_cla (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef NSA_OVERFLOW_FLAG_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    // Start from a clean result so partial sums never show old nibbles.
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef NSA_OVERFLOW_FLAG_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIB_CNT; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
`ifdef NSA_OVERFLOW_FLAG_EN
                    // Carry into the MSB is recovered as a^b^s at that bit position.
                    ovf_d   = slice_a[NIBBLE_W-1] ^ slice_b[NIBBLE_W-1]
                            ^ slice_sum[NIBBLE_W-1] ^ slice_cout;
`endif
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef NSA_OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef NSA_OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef NSA_OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16 and WIDTH=8 against an arithmetic reference.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel16 = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic [63:0] a_drv = '0;
    logic [63:0] b_drv = '0;

    logic        in_ready16, out_valid16, cout16;
    logic [15:0] sum16;
    logic        in_ready8, out_valid8, cout8;
    logic [7:0]  sum8;
    logic        in_valid16, in_valid8;

    logic        in_ready_s, out_valid_s, cout_s;
    logic [63:0] sum_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign in_valid16  = in_valid & sel16;
    assign in_valid8   = in_valid & ~sel16;
    assign in_ready_s  = sel16 ? in_ready16  : in_ready8;
    assign out_valid_s = sel16 ? out_valid16 : out_valid8;
    assign cout_s      = sel16 ? cout16      : cout8;
    assign sum_s       = sel16 ? {48'd0, sum16} : {56'd0, sum8};

`ifdef NSA_OVERFLOW_FLAG_EN
    logic ovf16, ovf8, ovf_s;
    assign ovf_s = sel16 ? ovf16 : ovf8;
`endif

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a_drv[15:0]),
        .b         (b_drv[15:0]),
        .cin       (cin),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .sum       (sum16),
`ifdef NSA_OVERFLOW_FLAG_EN
        .ovf       (ovf16),
`endif
        .cout      (cout16)
    );

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a_drv[7:0]),
        .b         (b_drv[7:0]),
        .cin       (cin),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .sum       (sum8),
`ifdef NSA_OVERFLOW_FLAG_EN
        .ovf       (ovf8),
`endif
        .cout      (cout8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller is positioned away from the clock edge with the DUT idle.
    // hold = cycles of out_ready=0 in DONE; hold=0 keeps out_ready high throughout.
    task automatic txn(input int w, input logic [63:0] aa, input logic [63:0] bb,
                       input logic ci, input int hold, input int exp_busy);
        logic [63:0] mask, es, got_s;
        logic [64:0] full;
        logic        ec, got_c;
        int          edges, busy, lat, held, fails_before;
`ifdef NSA_OVERFLOW_FLAG_EN
        logic        eo, got_o;
        got_o = 1'bx;
`endif
        got_s = 'x;
        got_c = 1'bx;
        fails_before = n_fail;
        mask = (64'd1 << w) - 64'd1;
        full = {1'b0, aa & mask} + {1'b0, bb & mask} + 65'(ci);
        es   = full[63:0] & mask;
        ec   = full[w];
`ifdef NSA_OVERFLOW_FLAG_EN
        eo   = (aa[w-1] == bb[w-1]) && (es[w-1] != aa[w-1]);
`endif
        sel16 = (w == 16);
        #0;
        check("in_ready_idle", in_ready_s, 1);
        a_drv = aa; b_drv = bb; cin = ci;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        // Scramble operands after acceptance; they must not affect the result.
        in_valid = 1'b0;
        a_drv = {$urandom, $urandom};
        b_drv = {$urandom, $urandom};
        cin   = 1'($urandom_range(0, 1));
        edges = 0; busy = 0; lat = -1; held = 0;
        while (in_ready_s == 1'b0 && edges < 200) begin
            busy++;
            if (out_valid_s) begin
                if (lat < 0) begin
                    lat   = edges;
                    got_s = sum_s;
                    got_c = cout_s;
`ifdef NSA_OVERFLOW_FLAG_EN
                    got_o = ovf_s;
`endif
                end else begin
                    check("sum_stable", sum_s, got_s);
                    check("cout_stable", cout_s, got_c);
                end
                if (held == hold) out_ready = 1'b1;
                else held++;
            end else if (lat >= 0) begin
                check("out_valid_held", out_valid_s, 1);
            end
            @(posedge clk); #1;
            edges++;
        end
        out_ready = 1'b0;
        check("no_timeout", edges < 200, 1);
        check("latency", lat, w / 4);
        if (exp_busy >= 0) check("in_ready_low_cycles", busy, exp_busy);
        check("out_valid_after_return", out_valid_s, 0);
        check("sum", got_s, es);
        check("cout", got_c, ec);
`ifdef NSA_OVERFLOW_FLAG_EN
        check("ovf", got_o, eo);
`endif
        check("sum_retained", sum_s, es);
        $display("txn w=%0d a=%h b=%h cin=%0d sum=%h cout=%0d lat=%0d %s",
                 w, aa & mask, bb & mask, ci, got_s, got_c, lat,
                 (n_fail == fails_before) ? "ok" : "bad");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        int hold;
        logic [63:0] ra, rb;

        repeat (2) @(negedge clk);
        check("rst_sum16", {48'd0, sum16}, 0);
        check("rst_cout16", cout16, 0);
        check("rst_out_valid16", out_valid16, 0);
        check("rst_in_ready16", in_ready16, 1);
        check("rst_sum8", {56'd0, sum8}, 0);
        check("rst_out_valid8", out_valid8, 0);
        reset = 1'b0;

        // Accepted on the very first edge after reset release.
        txn(16, 64'hFFFF, 64'h0001, 1'b0, 0, 5);
        @(negedge clk); txn(16, 64'h1234, 64'h4321, 1'b1, 0, 5);
        @(negedge clk); txn(16, 64'h00FF, 64'h0001, 1'b0, 10, 15);
        @(negedge clk); txn(16, 64'h7FFF, 64'h0001, 1'b0, 0, 5);
        @(negedge clk); txn(16, 64'hFFFF, 64'hFFFF, 1'b0, 0, 5);
        @(negedge clk); txn(8,  64'h00FF, 64'h0001, 1'b1, 2, -1);

        // Reset two cycles into RUN discards the transaction.
        @(negedge clk);
        sel16 = 1'b1;
        a_drv = 64'hAAAA; b_drv = 64'h5555; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check("midrun_rst_sum", {48'd0, sum16}, 0);
        check("midrun_rst_cout", cout16, 0);
        check("midrun_rst_out_valid", out_valid16, 0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            seen_valid |= out_valid16;
        end
        out_ready = 1'b0;
        check("midrun_rst_no_out_valid", seen_valid, 0);
        check("midrun_rst_in_ready", in_ready16, 1);
        @(negedge clk); txn(16, 64'd1, 64'd2, 1'b0, 0, 5);

        for (int wsel = 0; wsel < 2; wsel++) begin
            for (int n = 0; n < 512; n++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (n % 37 == 0) ra = '1;
                if (n % 41 == 0) rb = '1;
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                @(negedge clk);
                txn(wsel == 0 ? 8 : 16, ra, rb, 1'($urandom_range(0, 1)), hold,
                    hold == 0 ? ((wsel == 0 ? 8 : 16) / 4 + 1) : -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
